// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared types and constants for the VGA memory arbiter
package vga_pkg;

  localparam int STARVE_W = 8;

  typedef enum logic [1:0] {
    NONE,
    DISP,
    CPU
  } owner_e;

  typedef enum logic [1:0] {
    C_IDLE,
    C_RD,
    C_WR,
    C_ACK
  } cpu_state_e;

endpackage

// File: rtl/vga_mem_arbiter_if.sv
// rtl/vga_mem_arbiter_if.sv - display fetch, processor and RAM signals of the arbiter
interface vga_mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 8
);
  logic              disp_req;
  logic [ADDR_W-1:0] disp_addr;
  logic [DATA_W-1:0] disp_data;
  logic              disp_valid;
  logic              disp_miss;
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_ack;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output disp_req, disp_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata,
    input  disp_data, disp_valid, disp_miss, cpu_rdata, cpu_ack,
           mem_en, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  disp_req, disp_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata,
    output disp_data, disp_valid, disp_miss, cpu_rdata, cpu_ack,
           mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/vga_arb_tag_pipe.sv
// rtl/vga_arb_tag_pipe.sv - MEM_LAT-deep owner tag pipe that follows reads to the RAM output
module vga_arb_tag_pipe
  import vga_pkg::*;
#(
  parameter int MEM_LAT = 1
) (
  input  logic   clk,
  input  logic   reset,
  input  owner_e tag_in,
  output owner_e tag_out
);

  owner_e stage [MEM_LAT];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < MEM_LAT; i++) stage[i] <= NONE;
    end else begin
      stage[0] <= tag_in;
      for (int i = 1; i < MEM_LAT; i++) stage[i] <= stage[i-1];
    end
  end

  assign tag_out = stage[MEM_LAT-1];

endmodule

// File: rtl/vga_mem_arbiter.sv
// rtl/vga_mem_arbiter.sv - display-priority arbiter for the frame-buffer RAM
// Optional starvation guard (forced processor slot, disp_miss) under VGA_ARB_STARVE_EN.
module vga_mem_arbiter
  import vga_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 8,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 16
) (
  input  logic             clk,
  input  logic             reset,
  vga_mem_arbiter_if.slave bus
);

  if (MEM_LAT < 1 || MEM_LAT > 4 || STARVE_MAX < 2 || STARVE_MAX > 255) begin : g_param_check
    $error("vga_mem_arbiter: MEM_LAT or STARVE_MAX out of range");
  end

  cpu_state_e        state;
  owner_e            grant_owner;
  owner_e            ret_owner;
  logic              cpu_idle;
  logic              forced;
  logic              disp_grant;
  logic              cpu_grant;
  logic              rd_done;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] disp_data;
  logic              disp_valid;
  logic              disp_miss;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_ack;

  assign cpu_idle = (state == C_IDLE);

`ifdef VGA_ARB_STARVE_EN
  logic [STARVE_W-1:0] starve_cnt;

  assign forced = cpu_idle && bus.cpu_req && (starve_cnt >= STARVE_W'(STARVE_MAX));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starve_cnt <= '0;
    end else if (!bus.cpu_req || cpu_grant) begin
      starve_cnt <= '0;
    end else if (cpu_idle && disp_grant && starve_cnt != '1) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end
`else
  assign forced = 1'b0;
`endif

  assign disp_grant = !forced && bus.disp_req;
  assign cpu_grant  = forced || (!bus.disp_req && cpu_idle && bus.cpu_req);

  always_comb begin
    grant_owner = NONE;
    if (cpu_grant && !bus.cpu_we) grant_owner = CPU;
    else if (disp_grant)          grant_owner = DISP;
  end

  vga_arb_tag_pipe #(.MEM_LAT(MEM_LAT)) u_tag_pipe (
    .clk     (clk),
    .reset   (reset),
    .tag_in  (grant_owner),
    .tag_out (ret_owner)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= C_IDLE;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      disp_data  <= '0;
      disp_valid <= 1'b0;
      disp_miss  <= 1'b0;
      cpu_rdata  <= '0;
      cpu_ack    <= 1'b0;
      rd_done    <= 1'b0;
    end else begin
      mem_en    <= disp_grant || cpu_grant;
      mem_we    <= cpu_grant && bus.cpu_we;
      disp_miss <= forced && bus.disp_req;
      if (cpu_grant) begin
        mem_addr  <= bus.cpu_addr;
        mem_wdata <= bus.cpu_wdata;
      end else if (disp_grant) begin
        mem_addr  <= bus.disp_addr;
      end

      disp_valid <= (ret_owner == DISP);
      if (ret_owner == DISP) disp_data <= bus.mem_rdata;
      // Processor read data is captured here and acknowledged one cycle later.
      rd_done <= (ret_owner == CPU);
      if (ret_owner == CPU) cpu_rdata <= bus.mem_rdata;

      cpu_ack <= 1'b0;
      case (state)
        C_IDLE: begin
          if (cpu_grant) begin
            if (bus.cpu_we) state <= C_WR;
            else            state <= C_RD;
          end
        end
        C_RD: begin
          if (rd_done) begin
            state   <= C_ACK;
            cpu_ack <= 1'b1;
          end
        end
        C_WR: begin
          state   <= C_ACK;
          cpu_ack <= 1'b1;
        end
        default: state <= C_IDLE;
      endcase
    end
  end

  assign bus.mem_en     = mem_en;
  assign bus.mem_we     = mem_we;
  assign bus.mem_addr   = mem_addr;
  assign bus.mem_wdata  = mem_wdata;
  assign bus.disp_data  = disp_data;
  assign bus.disp_valid = disp_valid;
  assign bus.disp_miss  = disp_miss;
  assign bus.cpu_rdata  = cpu_rdata;
  assign bus.cpu_ack    = cpu_ack;

endmodule

// File: tb/tb_vga_mem_arbiter.sv
// tb/tb_vga_mem_arbiter.sv - self-checking bench for vga_mem_arbiter (honours VGA_ARB_STARVE_EN)
module tb_vga_mem_arbiter;

  localparam int AW   = 32;
  localparam int DW   = 8;
  localparam int LAT  = 1;
  localparam int SMAX = 4;
  localparam int NCYC = 8192;
`ifdef VGA_ARB_STARVE_EN
  localparam bit STARVE_ON = 1'b1;
`else
  localparam bit STARVE_ON = 1'b0;
`endif

  logic clk   = 1'b0;
  logic reset = 1'b1;

  vga_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  vga_mem_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT), .STARVE_MAX(SMAX)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Frame-buffer RAM: asynchronous read of the registered address (one cycle of latency
  // after the arbiter's address register), synchronous write. Non-read cycles return noise.
  bit   [7:0] ram     [1024];
  bit         written [1024];
  logic [7:0] junk = 8'h5A;

  function automatic logic [7:0] pat(input logic [9:0] a);
    return a[7:0] ^ 8'hE5;
  endfunction

  always @(posedge clk) begin
    junk <= 8'($urandom);
    if (bus.mem_en && bus.mem_we) begin
      ram[bus.mem_addr[9:0]]     <= bus.mem_wdata;
      written[bus.mem_addr[9:0]] <= 1'b1;
    end
  end

  always_comb begin
    bus.mem_rdata = junk;
    if (bus.mem_en && !bus.mem_we)
      bus.mem_rdata = written[bus.mem_addr[9:0]] ? ram[bus.mem_addr[9:0]] : pat(bus.mem_addr[9:0]);
  end

  // Reference model: expected events scheduled by absolute cycle number.
  bit   [7:0]  mmem     [1024];
  bit          exp_en   [NCYC];
  bit          exp_we   [NCYC];
  bit          exp_dv   [NCYC];
  bit          exp_miss [NCYC];
  bit          exp_ack  [NCYC];
  bit          exp_rdc  [NCYC];
  bit   [31:0] exp_addr [NCYC];
  bit   [7:0]  exp_wd   [NCYC];
  bit   [7:0]  exp_dd   [NCYC];
  bit   [7:0]  exp_cd   [NCYC];

  int         n_assert = 0;
  int         n_fail   = 0;
  int         cyc      = 0;
  int         m_free   = 0;
  int         cnt      = 0;
  logic [7:0] last_pix = 8'h00;
  bit         cpu_active  = 1'b0;
  bit         cpu_granted = 1'b0;
  int         cpu_ack_c   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s cycle %0d observed=%0h expected=%0h", tag, cyc, obs, expv);
    end
  endtask

  task automatic check_zero(input string pfx);
    chk({pfx, "_mem_en"},     32'(bus.mem_en),     32'h0);
    chk({pfx, "_mem_we"},     32'(bus.mem_we),     32'h0);
    chk({pfx, "_mem_addr"},   bus.mem_addr,        32'h0);
    chk({pfx, "_mem_wdata"},  32'(bus.mem_wdata),  32'h0);
    chk({pfx, "_disp_data"},  32'(bus.disp_data),  32'h0);
    chk({pfx, "_disp_valid"}, 32'(bus.disp_valid), 32'h0);
    chk({pfx, "_disp_miss"},  32'(bus.disp_miss),  32'h0);
    chk({pfx, "_cpu_rdata"},  32'(bus.cpu_rdata),  32'h0);
    chk({pfx, "_cpu_ack"},    32'(bus.cpu_ack),    32'h0);
  endtask

  task automatic model_edge();
    bit idle, forced, cg, dg;
    int a;
    idle   = (cyc >= m_free);
    forced = STARVE_ON && (cnt >= SMAX) && idle && bus.cpu_req;
    cg     = forced || (!bus.disp_req && idle && bus.cpu_req);
    dg     = !forced && bus.disp_req;
    if (cg) begin
      exp_en[cyc+1]   = 1'b1;
      exp_we[cyc+1]   = bus.cpu_we;
      exp_addr[cyc+1] = bus.cpu_addr;
      if (bus.cpu_we) begin
        exp_wd[cyc+1] = bus.cpu_wdata;
        mmem[bus.cpu_addr[9:0]] = bus.cpu_wdata;
        a = cyc + 2;
      end else begin
        a = cyc + 2 + LAT;
        exp_rdc[a] = 1'b1;
        exp_cd[a]  = mmem[bus.cpu_addr[9:0]];
      end
      exp_ack[a]  = 1'b1;
      m_free      = a + 1;
      cpu_granted = 1'b1;
      cpu_ack_c   = a;
      if (forced && bus.disp_req) exp_miss[cyc+1] = 1'b1;
    end else if (dg) begin
      exp_en[cyc+1]       = 1'b1;
      exp_addr[cyc+1]     = bus.disp_addr;
      exp_dv[cyc+1+LAT]   = 1'b1;
      exp_dd[cyc+1+LAT]   = mmem[bus.disp_addr[9:0]];
    end
    if (!bus.cpu_req || cg) cnt = 0;
    else if (idle && dg && cnt < 255) cnt++;
  endtask

  task automatic check_cycle();
    chk("mem_en", 32'(bus.mem_en), 32'(exp_en[cyc]));
    chk("mem_we", 32'(bus.mem_we), 32'(exp_we[cyc]));
    if (exp_en[cyc]) chk("mem_addr", bus.mem_addr, exp_addr[cyc]);
    if (exp_we[cyc]) chk("mem_wdata", 32'(bus.mem_wdata), 32'(exp_wd[cyc]));
    chk("disp_valid", 32'(bus.disp_valid), 32'(exp_dv[cyc]));
    if (exp_dv[cyc]) last_pix = exp_dd[cyc];
    chk("disp_data", 32'(bus.disp_data), 32'(last_pix));
    chk("disp_miss", 32'(bus.disp_miss), 32'(exp_miss[cyc]));
    chk("cpu_ack", 32'(bus.cpu_ack), 32'(exp_ack[cyc]));
    if (exp_rdc[cyc]) chk("cpu_rdata", 32'(bus.cpu_rdata), 32'(exp_cd[cyc]));
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    cyc++;
    check_cycle();
    if (cpu_active && cpu_granted && cyc > cpu_ack_c) begin
      cpu_active  = 1'b0;
      cpu_granted = 1'b0;
      bus.cpu_req = 1'b0;
    end
  endtask

  task automatic cpu_start(input bit we, input logic [31:0] addr, input logic [7:0] wd);
    cpu_active    = 1'b1;
    cpu_granted   = 1'b0;
    bus.cpu_req   = 1'b1;
    bus.cpu_we    = we;
    bus.cpu_addr  = addr;
    bus.cpu_wdata = wd;
  endtask

  task automatic cpu_finish(input int budget);
    for (int i = 0; i < budget && cpu_active; i++) tick();
  endtask

  task automatic mid_reset();
    #2 reset = 1'b1;
    #1 check_zero("mid_reset");
    bus.disp_req = 1'b0;
    bus.cpu_req  = 1'b0;
    cpu_active   = 1'b0;
    cpu_granted  = 1'b0;
    for (int i = cyc; i < NCYC; i++) begin
      exp_en[i] = 0; exp_we[i] = 0; exp_dv[i] = 0; exp_miss[i] = 0;
      exp_ack[i] = 0; exp_rdc[i] = 0;
    end
    @(posedge clk);
    #1;
    cyc++;
    check_zero("reset_hold");
    reset    = 1'b0;
    m_free   = cyc;
    cnt      = 0;
    last_pix = 8'h00;
  endtask

  initial begin
    int p;
    for (int i = 0; i < 1024; i++) mmem[i] = pat(10'(i));
    bus.disp_req  = 1'b0;
    bus.disp_addr = '0;
    bus.cpu_req   = 1'b0;
    bus.cpu_we    = 1'b0;
    bus.cpu_addr  = '0;
    bus.cpu_wdata = '0;

    @(posedge clk);
    #1;
    check_zero("reset");
    reset = 1'b0;
    cyc   = 0;

    // Single display read of 0x40 (RAM holds 0xA5 there).
    bus.disp_req  = 1'b1;
    bus.disp_addr = 32'h40;
    tick();
    bus.disp_req = 1'b0;
    repeat (3) tick();

    // Processor write 0x3C to 0x100, then read it back.
    cpu_start(1'b1, 32'h100, 8'h3C);
    cpu_finish(10);
    cpu_start(1'b0, 32'h100, 8'h00);
    cpu_finish(10);

    // Simultaneous requests: display wins, processor follows.
    bus.disp_req  = 1'b1;
    bus.disp_addr = 32'h41;
    cpu_start(1'b0, 32'h40, 8'h00);
    tick();
    bus.disp_req = 1'b0;
    cpu_finish(10);

    // Continuous display traffic with a held processor read.
    cpu_start(1'b0, 32'h100, 8'h00);
    for (int i = 0; i < 12; i++) begin
      bus.disp_req  = 1'b1;
      bus.disp_addr = 32'(i + 200);
      tick();
    end
    bus.disp_req = 1'b0;
    cpu_finish(10);
    repeat (3) tick();

    // Reset with a display read in flight, then with a processor read in flight.
    bus.disp_req  = 1'b1;
    bus.disp_addr = 32'h55;
    tick();
    mid_reset();
    repeat (4) tick();
    cpu_start(1'b0, 32'h100, 8'h00);
    tick();
    mid_reset();
    repeat (4) tick();

    // Randomized traffic with varying display load.
    for (int blk = 0; blk < 16; blk++) begin
      case (blk % 4)
        0: p = 30;
        1: p = 100;
        2: p = 0;
        default: p = 70;
      endcase
      for (int i = 0; i < 100; i++) begin
        bus.disp_req  = ($urandom_range(0, 99) < p);
        bus.disp_addr = $urandom;
        if (!cpu_active && $urandom_range(0, 3) == 0)
          cpu_start(1'($urandom), 32'($urandom_range(0, 31)), 8'($urandom));
        tick();
      end
    end
    bus.disp_req = 1'b0;
    cpu_finish(20);

    // Reduced raster sweep, display only.
    for (int v = 0; v < 25; v++) begin
      for (int h = 0; h < 40; h++) begin
        bus.disp_req  = 1'b1;
        bus.disp_addr = 32'(v * 600 + h);
        tick();
      end
    end
    bus.disp_req = 1'b0;
    repeat (5) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_mem_arbiter.md
# vga_mem_arbiter

Arbitrates a single-port video memory between the VGA display fetch path and the processor. The display path is driven by the address decoder's `video_address` output. The processor path is a req/ack load/store port. Display reads have priority so scan-out never stalls. The processor is served in idle slots, and a starvation guard can steal a display slot. The block sits between `vgaAddressDecoder`/`vgaModule` and the frame-buffer RAM.

## Interface
- `ADDR_W`, 32: memory address width (matches `video_address`).
- `DATA_W`, 8: pixel/word width.
- `MEM_LAT`, 1: RAM read latency in cycles (1..4), from the edge that samples `mem_addr` to valid `mem_rdata`.
- `STARVE_MAX`, 16: consecutive denied processor cycles before a forced processor slot (2..255).
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `disp_req` in 1: display fetch request; 1-cycle pulse per pixel.
- `disp_addr` in ADDR_W: fetch address, valid with `disp_req`.
- `disp_data` out DATA_W: fetched pixel; holds its last value.
- `disp_valid` out 1: 1-cycle pulse; `disp_data` is updated.
- `disp_miss` out 1: 1-cycle pulse; a display request was displaced.
- `cpu_req` in 1: processor request; held until `cpu_ack`.
- `cpu_we` in 1: write (1) or read (0); stable while `cpu_req` is high.
- `cpu_addr` in ADDR_W: processor address; stable while `cpu_req` is high.
- `cpu_wdata` in DATA_W: write data; stable while `cpu_req` is high.
- `cpu_rdata` out DATA_W: read data, valid with `cpu_ack` on reads.
- `cpu_ack` out 1: 1-cycle completion pulse.
- `mem_en` out 1: memory access strobe (registered).
- `mem_we` out 1: memory write strobe (registered).
- `mem_addr` out ADDR_W: memory address (registered).
- `mem_wdata` out DATA_W: memory write data (registered).
- `mem_rdata` in DATA_W: memory read data.

## Operation
- **Grant per sampling edge.** At most one access is granted per edge, evaluated in this order:
  - Forced: starvation count is at least `STARVE_MAX`, the processor FSM is in C_IDLE and `cpu_req` is high → grant the processor.
  - Otherwise, if `disp_req` is high → grant the display.
  - Otherwise, if the processor FSM is in C_IDLE and `cpu_req` is high → grant the processor.
  - Otherwise → no access.
- **Processor FSM.**
  - C_IDLE → C_RD on a granted read.
  - C_IDLE → C_WR on a granted write.
  - C_RD → C_ACK when the return tag pipe delivers the processor read.
  - C_WR → C_ACK after 1 cycle.
  - C_ACK → C_IDLE unconditionally, driving `cpu_ack` for 1 cycle.
  - A new processor grant is possible only in C_IDLE, so at most one processor transaction is outstanding.
- **Starvation counter** (8 bits, saturating).
  - Increments on each edge where the FSM is in C_IDLE, `cpu_req` is high and the grant went to the display.
  - Clears on any processor grant, and whenever `cpu_req` is low.
- **Displaced display request.** If a forced processor grant coincides with `disp_req`, `disp_miss` pulses and `disp_valid` does not pulse for that request. `disp_data` retains the previous pixel, so the display repeats it.
- **Read return routing.** Each granted read pushes an owner tag (NONE/DISP/CPU) into a `MEM_LAT`-deep shift pipe. `mem_rdata` is routed by the tag emerging from the pipe.
- **Mid-operation reset.** Reset clears all state and all in-flight tags. Data returning after reset is discarded.
- **Reset values:** `disp_data`=0, `cpu_rdata`=0, all strobes and pulses 0, `mem_addr`=0, `mem_wdata`=0, FSM=C_IDLE, counter=0.

## Timing
- **Request to memory:** request sampled at edge k → `mem_en` (and `mem_we` for writes) high during cycle k+1, for exactly 1 cycle.
- **Display reads:** `disp_valid` and `disp_data` update after edge k+1+`MEM_LAT`.
  - With `MEM_LAT`=1: 2 cycles after the request edge.
- **Processor reads:** `cpu_ack` and `cpu_rdata` are valid in cycle k+2+`MEM_LAT`.
- **Processor writes:** `cpu_ack` in cycle k+2.
- **Bus occupancy:** back-to-back display requests give 100% bus use with no bubbles.
- **Processor held in request:** the processor must keep `cpu_req` high through the ack cycle. The ack cycle is never re-granted because the FSM is in C_ACK; `cpu_req` may drop the cycle after the ack.

## Configuration
- **With `VGA_ARB_STARVE_EN` defined:** the starvation counter, forced grant and `disp_miss` are present.
- **Without it:** strict display priority.
  - The counter logic is removed.
  - `disp_miss` is tied to 0.
  - The processor can wait indefinitely during active video.

## Structure
- **Package `vga_pkg`:** `owner_e` (NONE, DISP, CPU), `cpu_state_e` (C_IDLE, C_RD, C_WR, C_ACK) and the `STARVE_W`=8 constant.
- **Sub-module `vga_arb_tag_pipe`:** parameterized `MEM_LAT`-deep shift register of `owner_e` tags with asynchronous reset.
- **Top level:** grant logic, processor FSM, starvation counter and output registers.

## Test plan
- **Single display read:** reset, then `disp_req` with `disp_addr`=0x40, RAM returns 0xA5 → `mem_en` in cycle +1, `disp_valid` with 0xA5 in cycle +2 (`MEM_LAT`=1).
- **Processor write then read:**
  - Idle display, write 0x3C to 0x100 → `mem_we` in cycle +1, `cpu_ack` in cycle +2.
  - Read 0x100 → `cpu_rdata`=0x3C with `cpu_ack` in cycle +3.
- **Simultaneous requests:** `disp_req` and `cpu_req` in the same cycle → display granted; processor granted on the next free edge.
- **Starvation:** `VGA_ARB_STARVE_EN`, `STARVE_MAX`=4, continuous `disp_req` plus a held processor read → processor granted on the 5th edge, `disp_miss` pulses once, `disp_data` unchanged.
- **Reset with read in flight:** assert `reset` with a read in flight (`MEM_LAT`=3) → no `disp_valid`/`cpu_ack` afterwards, and all outputs 0.
- **Full-frame scan:** a 600×400 sweep of `hcnt`/`vcnt` through `vgaAddressDecoder` with no processor traffic → every fetch returns, with zero `disp_miss`.
